// File: rtl/hamming_tx_sched_if.sv
// Handshake bundle between two byte requesters, the Hamming scheduler and the codeword sink.
// The scheduler uses the slave modport and the surrounding environment uses the master modport.
interface hamming_tx_sched_if;
   logic       req0_valid;
   logic [7:0] req0_data;
   logic       req0_ready;
   logic       req1_valid;
   logic [7:0] req1_data;
   logic       req1_ready;
   logic       cw_valid;
   logic [6:0] cw_data;
   logic       cw_last;
   logic       cw_src;
   logic       cw_ready;

   modport master (
      output req0_valid, req0_data, input req0_ready,
      output req1_valid, req1_data, input req1_ready,
      input  cw_valid, cw_data, cw_last, cw_src,
      output cw_ready
   );

   modport slave (
      input  req0_valid, req0_data, output req0_ready,
      input  req1_valid, req1_data, output req1_ready,
      output cw_valid, cw_data, cw_last, cw_src,
      input  cw_ready
   );
endinterface

// File: rtl/hamming_tx_sched.sv
// Round-robin byte scheduler that emits each byte as two Hamming(7,4) codewords, low nibble first.
// Optional codeword handshake counter: define HAMMING_TX_STATS_EN to add the cw_count port.
module hamming_encoder (
   input  logic [3:0] nibble,
   output logic [6:0] codeword
);
   // Bit order {p1,p2,d0,p4,d1,d2,d3}
   assign codeword = {nibble[0] ^ nibble[1] ^ nibble[3],
                      nibble[0] ^ nibble[2] ^ nibble[3],
                      nibble[0],
                      nibble[1] ^ nibble[2] ^ nibble[3],
                      nibble[1],
                      nibble[2],
                      nibble[3]};
endmodule

module hamming_tx_sched (
   input  logic               clk,
   input  logic               rst_n,
   hamming_tx_sched_if.slave  bus,
   output logic               busy
`ifdef HAMMING_TX_STATS_EN
   ,
   output logic [15:0]        cw_count
`endif
);
   typedef enum logic [1:0] {IDLE, LO, HI} state_t;

   state_t     state_q;
   logic [7:0] byte_q;
   logic       src_q;
   logic       ptr_q;
   logic       valid_q;
   logic       last_q;
   logic       busy_q;
   logic       grant0;
   logic       grant1;
   logic [3:0] enc_nibble;
   logic [6:0] enc_codeword;

   // A lone requester wins outright; the pointer only breaks ties
   assign grant0 = (state_q == IDLE) && bus.req0_valid && (!bus.req1_valid || !ptr_q);
   assign grant1 = (state_q == IDLE) && bus.req1_valid && (!bus.req0_valid ||  ptr_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         byte_q  <= '0;
         src_q   <= 1'b0;
         ptr_q   <= 1'b0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (grant0 || grant1) begin
                  byte_q  <= grant1 ? bus.req1_data : bus.req0_data;
                  src_q   <= grant1;
                  state_q <= LO;
                  valid_q <= 1'b1;
                  last_q  <= 1'b0;
                  busy_q  <= 1'b1;
               end
            end
            LO: begin
               if (bus.cw_ready) begin
                  state_q <= HI;
                  last_q  <= 1'b1;
               end
            end
            HI: begin
               if (bus.cw_ready) begin
                  state_q <= IDLE;
                  valid_q <= 1'b0;
                  last_q  <= 1'b0;
                  busy_q  <= 1'b0;
                  ptr_q   <= ~src_q;
               end
            end
            default: begin
               state_q <= IDLE;
               valid_q <= 1'b0;
               last_q  <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign enc_nibble = last_q ? byte_q[7:4] : byte_q[3:0];

   hamming_encoder u_encoder (
      .nibble   (enc_nibble),
      .codeword (enc_codeword)
   );

   // Codeword fields are forced to zero whenever nothing is presented
   assign bus.cw_valid   = valid_q;
   assign bus.cw_data    = valid_q ? enc_codeword : 7'd0;
   assign bus.cw_last    = last_q;
   assign bus.cw_src     = valid_q & src_q;
   assign bus.req0_ready = grant0;
   assign bus.req1_ready = grant1;
   assign busy           = busy_q;

`ifdef HAMMING_TX_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cw_count <= 16'd0;
      end else if (valid_q && bus.cw_ready) begin
         cw_count <= cw_count + 16'd1;
      end
   end
`endif
endmodule
